bch_syndrome_collect: RTL and testbench
=======================================

Name: bch_syndrome_collect

Overview:
- Collects one frame of T syndrome words, arriving serially from the syndrome generator, into a parallel buffer.
- Flags per-syndrome and whole-frame nonzero status, using the codebase's nonzero_cla per word, so the downstream error locator solver can be skipped when the frame is error-free.
- Holds the result under a valid/ready handshake and detects malformed frame lengths.

Parameters:
- M, 4, GF(2^M) symbol width in bits (width of each syndrome word).
- T, 3, syndrome words per frame; also the buffer depth.
- W, 1, LUT bits per input, passed to the nonzero_cla instances.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  M  syndrome word.
- in_last  in  1  final word of the frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_syn  out  T*M  buffered syndromes; word k sits at out_syn[k*M +: M].
- out_nz  out  T  per-word nonzero flags; bit k set iff word k != 0.
- out_err  out  1  OR of out_nz (frame contains errors).
- out_len_err  out  1  frame length differed from T.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- A beat is accepted when in_valid && in_ready. Accept index idx counts 0..T-1 and is ceil(log2(T+1)) bits wide.
- States:
  - COLLECT: in_ready=1.
  - DRAIN: in_ready=1; beats are discarded.
  - HOLD: in_ready=0; out_valid=1.
- Reset (synchronous, active-high): state=COLLECT, idx=0, out_valid=0, out_syn=0, out_nz=0, out_err=0, out_len_err=0. in_ready is forced 0 while reset is high and goes to 1 in the first cycle after reset deasserts.
- COLLECT, accepted beat:
  - Word stored at slot idx. Accepting at idx==0 also clears all other slots, so slots beyond a short frame read as zero.
  - in_last && idx==T-1 -> HOLD, len_err=0.
  - in_last && idx<T-1 -> HOLD, len_err=1 (short frame; missing words are zero).
  - !in_last && idx==T-1 -> DRAIN, len_err=1 (long frame).
  - Otherwise idx++ and stay in COLLECT.
- DRAIN: beats are accepted and dropped. The accepted beat with in_last -> HOLD. The buffer is not modified.
- HOLD:
  - out_valid=1. out_syn, out_nz, out_err and out_len_err are stable for as long as out_valid && !out_ready.
  - out_valid && out_ready -> COLLECT next cycle, idx=0, out_valid=0. No new beat is accepted in the handshake cycle.
- Latency: out_valid rises in the cycle after the in_last beat is accepted.
  - out_nz and out_err are registered, computed from the buffer contents including that final beat.
  - No combinational path from in_* to out_*, and none from out_ready to in_ready.
- Throughput: one frame per T+1 cycles minimum (T beats plus one handshake cycle).
- Nonzero detection: one nonzero_cla instance (parameters M, W) per slot, driven from the next-buffer value; results registered into out_nz. out_err = |out_nz, also registered.
- in_valid low in any state: no state change.
- T==1: idx stays 0; every accepted beat without in_last -> DRAIN.
- Reset asserted mid-frame or in HOLD: the partial frame and any pending result are discarded; all outputs return to their reset values.

Test Plan:
1. M=4, T=3: beats 0x3, 0x0, 0x9, last on 3rd, out_ready=1 -> out_valid one cycle after 3rd beat; out_syn=0x903, out_nz=3'b101, out_err=1, out_len_err=0; COLLECT again 1 cycle later.
2. All-zero frame 0,0,0 -> out_syn=0, out_nz=0, out_err=0, out_len_err=0.
3. Short frame: 0x5 then 0x6 with last; the previous frame left 0xF in slot 2 -> out_syn=0x065, out_nz=3'b011, out_len_err=1.
4. Long frame: 0x1,0x2,0x3,0x4,0x5 (last on 5th) -> DRAIN absorbs the 4th and 5th beats with in_ready=1; then out_syn=0x321, out_len_err=1, out_err=1.
5. Backpressure: out_ready=0 for 5 cycles after out_valid; in_valid held high -> in_ready=0 and outputs stable throughout; accept occurs on the first out_ready=1 cycle; new frame beats are accepted from the next cycle.
6. Reset pulse after the 2nd beat of a frame -> all outputs zero, idx=0; a fresh 3-beat frame 0x1,0x1,0x1 yields out_syn=0x111, out_nz=3'b111, out_len_err=0.

Source files
------------

// File: rtl/bch_syndrome_collect.sv
// Serial-to-parallel BCH syndrome buffer with nonzero flags,
// frame length checking and a valid/ready result hold.
module nonzero_cla #(
  parameter int M = 4,
  parameter int W = 1
) (
  input  logic [M-1:0] d,
  output logic         nz
);
  localparam int G  = (M + W - 1) / W;
  localparam int PW = G * W;

  logic [PW-1:0] pad;
  logic [G-1:0]  grp;

  assign pad = PW'(d);

  for (genvar g = 0; g < G; g++) begin : g_grp
    assign grp[g] = |pad[g*W +: W];
  end

  assign nz = |grp;
endmodule

module bch_syndrome_collect #(
  parameter int M = 4,
  parameter int T = 3,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [T*M-1:0] out_syn,
  output logic [T-1:0]   out_nz,
  output logic           out_err,
  output logic           out_len_err
);
  localparam int IW = $clog2(T + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          acc;
  logic          col_acc;
  logic [T*M-1:0] syn_nxt;
  logic [T-1:0]  nz_nxt;

  assign acc     = in_valid && in_ready;
  assign col_acc = acc && (state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == HOLD) begin
        idx <= '0;
      end else if (col_acc) begin
        if (in_last || idx == LAST_IDX) idx <= '0;
        else idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: begin
        if (acc) begin
          if (in_last) state_nxt = HOLD;
          else if (idx == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (acc && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // in_ready depends only on state and reset, never on out_ready
  always_comb begin
    in_ready  = !reset && (state != HOLD);
    out_valid = (state == HOLD);
  end

  // the first word of a frame wipes stale slots so short frames pad with zero
  always_comb begin
    syn_nxt = out_syn;
    if (col_acc) begin
      if (idx == '0) syn_nxt = '0;
      for (int k = 0; k < T; k++) begin
        if (idx == IW'(k)) syn_nxt[k*M +: M] = in_data;
      end
    end
  end

  for (genvar k = 0; k < T; k++) begin : g_nz
    nonzero_cla #(
      .M(M),
      .W(W)
    ) u_nz (
      .d (syn_nxt[k*M +: M]),
      .nz(nz_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_syn     <= '0;
      out_nz      <= '0;
      out_err     <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      out_syn <= syn_nxt;
      out_nz  <= nz_nxt;
      out_err <= |nz_nxt;
      if (col_acc) begin
        if (in_last) out_len_err <= (idx != LAST_IDX);
        else if (idx == LAST_IDX) out_len_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bch_syndrome_collect.sv
// Directed checks of bch_syndrome_collect with M=4, T=3:
// normal, zero, short, long, backpressure and reset cases.
module tb_bch_syndrome_collect;
  localparam int M = 4;
  localparam int T = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [M-1:0]   in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [T*M-1:0] out_syn;
  logic [T-1:0]   out_nz;
  logic           out_err;
  logic           out_len_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bch_syndrome_collect #(
    .M(M),
    .T(T),
    .W(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_syn    (out_syn),
    .out_nz     (out_nz),
    .out_err    (out_err),
    .out_len_err(out_len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [M-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [T*M-1:0] syn,
                         input logic [T-1:0] nz, input logic err,
                         input logic len);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_syn"}, 32'(out_syn), 32'(syn));
    chk({tag, "_nz"}, 32'(out_nz), 32'(nz));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    chk({tag, "_len"}, 32'(out_len_err), 32'(len));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_syn"}, 32'(out_syn), 32'd0);
    chk({tag, "_nz"}, 32'(out_nz), 32'd0);
    chk({tag, "_err"}, 32'(out_err), 32'd0);
    chk({tag, "_len"}, 32'(out_len_err), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst");
    chk("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // normal frame, immediate handshake
    send(4'h3, 1'b0);
    send(4'h0, 1'b0);
    send(4'h9, 1'b1);
    chk_out("t1", 12'h903, 3'b101, 1'b1, 1'b0);
    chk("t1_hold_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_back_valid", 32'(out_valid), 32'd0);
    chk("t1_back_ready", 32'(in_ready), 32'd1);

    // all-zero frame
    send(4'h0, 1'b0);
    send(4'h0, 1'b0);
    send(4'h0, 1'b1);
    chk_out("t2", 12'h000, 3'b000, 1'b0, 1'b0);
    @(negedge clk);

    // leave 0xF in slot 2, then a short frame must clear it
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'hF, 1'b1);
    chk_out("fill", 12'hF21, 3'b111, 1'b1, 1'b0);
    @(negedge clk);
    send(4'h5, 1'b0);
    send(4'h6, 1'b1);
    chk_out("t3", 12'h065, 3'b011, 1'b1, 1'b1);
    @(negedge clk);

    // long frame drained
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    chk("t4_drain_ready", 32'(in_ready), 32'd1);
    chk("t4_drain_valid", 32'(out_valid), 32'd0);
    send(4'h4, 1'b0);
    chk("t4_drain_ready2", 32'(in_ready), 32'd1);
    chk("t4_drain_syn", 32'(out_syn), 32'h321);
    send(4'h5, 1'b1);
    chk_out("t4", 12'h321, 3'b111, 1'b1, 1'b1);
    @(negedge clk);

    // backpressure with in_valid held high
    out_ready = 1'b0;
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    send(4'h9, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'hA;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("t5_stall", 12'h987, 3'b111, 1'b1, 1'b0);
      chk("t5_stall_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs_valid", 32'(out_valid), 32'd0);
    chk("t5_hs_ready", 32'(in_ready), 32'd1);
    chk("t5_hs_syn", 32'(out_syn), 32'h987);
    @(negedge clk);
    chk("t5_first", 32'(out_syn), 32'h00A);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    chk_out("t5", 12'hCBA, 3'b111, 1'b1, 1'b0);
    @(negedge clk);

    // reset while holding a short-frame result
    out_ready = 1'b0;
    send(4'hD, 1'b1);
    chk_out("hold", 12'h00D, 3'b001, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_hold");
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // reset after two beats of a frame
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    send(4'h1, 1'b0);
    send(4'h1, 1'b0);
    send(4'h1, 1'b1);
    chk_out("t6", 12'h111, 3'b111, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
